// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 round key generator, one round key per handshake
// Optional round key store with registered read port: AES_KEY_STORE_EN
module aes_key_expand_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so byte b lives at bit offset (255-b)*8 = {~b, 3'b000}.
  assign dout = SBOX_TBL[{~din, 3'b000} +: 8];
endmodule

module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [127:0] Cipher_Key,
  input  logic         Key_Ready,
`ifdef AES_KEY_STORE_EN
  input  logic [3:0]   Rd_Idx,
  output logic [127:0] Rd_Key,
`endif
  output logic         Busy,
  output logic         Key_Valid,
  output logic [3:0]   Round_Idx,
  output logic [127:0] Round_Key,
  output logic         Done
);
  typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

  state_t        state;
  logic [7:0]    rcon;
  logic [31:0]   rot_word;
  logic [31:0]   sub_word;
  logic [31:0]   t_word;
  logic [31:0]   n0, n1, n2, n3;
  logic [127:0]  next_key;
  logic          hs;

  assign hs = Key_Valid && Key_Ready;

  // Rcon for the round being produced, i.e. Round_Idx+1.
  always_comb begin
    rcon = 8'h00;
    case (Round_Idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_word = {Round_Key[23:0], Round_Key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_key_expand_sbox u_sbox (
      .din  (rot_word[8*g +: 8]),
      .dout (sub_word[8*g +: 8])
    );
  end

  assign t_word   = sub_word ^ {rcon, 24'h000000};
  assign n0       = Round_Key[127:96] ^ t_word;
  assign n1       = Round_Key[95:64]  ^ n0;
  assign n2       = Round_Key[63:32]  ^ n1;
  assign n3       = Round_Key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Key_Valid <= 1'b0;
      Done      <= 1'b0;
      Round_Idx <= 4'd0;
      Round_Key <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            Round_Key <= Cipher_Key;
            Round_Idx <= 4'd0;
            Busy      <= 1'b1;
            Key_Valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (Key_Ready) begin
            if (Round_Idx == 4'(NUM_ROUNDS)) begin
              Key_Valid <= 1'b0;
              Done      <= 1'b1;
              state     <= FINISH;
            end else begin
              Round_Key <= next_key;
              Round_Idx <= Round_Idx + 4'd1;
            end
          end
        end
        FINISH: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy      <= 1'b0;
          Key_Valid <= 1'b0;
          Done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] key_store [0:10];

  // Survives a new Start so decryption can still read the previous schedule.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 11; i++) key_store[i] <= '0;
      Rd_Key <= '0;
    end else begin
      if (hs) key_store[Round_Idx] <= Round_Key;
      Rd_Key <= (Rd_Idx <= 4'd10) ? key_store[Rd_Idx] : '0;
    end
  end
`endif
endmodule
